// File: rtl/noc_mem_responder.sv
// NoC memory endpoint: request FIFO feeding a word-addressed synchronous SRAM.
// Optional build macro MEM_RESPONDER_WRITE_ACK_EN makes every write return an acknowledgement.
//
// Handshake rule for both ports: a transfer happens on the rising edge where
// valid and ready are both high; a raised valid holds its payload stable until
// that edge, and ready seen while valid is low has no effect.
module noc_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rq_valid,
  output logic        rq_ready,
  input  logic        rq_write,
  input  logic [31:0] rq_addr,
  input  logic [31:0] rq_wdata,
  input  logic [7:0]  rq_src,
  output logic        rs_valid,
  input  logic        rs_ready,
  output logic [7:0]  rs_dst,
  output logic        rs_write,
  output logic        rs_err,
  output logic [31:0] rs_rdata,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);

`ifdef MEM_RESPONDER_WRITE_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  logic [72:0] fifo_mem [FIFO_DEPTH];
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] sram_q;

  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic        hd_write;
  logic [31:0] hd_addr;
  logic [31:0] hd_wdata;
  logic [7:0]  hd_src;
  logic [29:0] off_word;
  logic        err;
  logic [AW-1:0] idx;
  logic        mem_we;
  logic        mem_re;

  // Full/empty come only from registered pointers, so a same-cycle pop never frees a slot early.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = ((wr_ptr ^ rd_ptr) == {1'b1, {PW{1'b0}}});
  assign rq_ready = !full;
  assign push     = rq_valid && !full;
  assign pop      = (state == IDLE) && !empty;

  assign {hd_write, hd_addr, hd_wdata, hd_src} = fifo_mem[rd_ptr[PW-1:0]];

  assign off_word = 30'((hd_addr - BASE_ADDR) >> 2);
  assign err      = (|hd_addr[1:0]) || ({2'b00, off_word} >= 32'(DEPTH_WORDS));
  assign idx      = off_word[AW-1:0];
  assign mem_we   = pop && hd_write && !err;
  assign mem_re   = pop && !hd_write && !err;

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[PW-1:0]] <= {rq_write, rq_addr, rq_wdata, rq_src};
    end
  end

  // SRAM array and its read register are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= hd_wdata;
    end
    if (mem_re) begin
      sram_q <= mem[idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rs_valid <= 1'b0;
      rs_dst   <= '0;
      rs_write <= 1'b0;
      rs_err   <= 1'b0;
      rs_rdata <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (PW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (PW+1)'(1);
      end
      case (state)
        IDLE: begin
          if (pop) begin
            if (!hd_write && !err) begin
              rs_dst   <= hd_src;
              rs_write <= 1'b0;
              rs_err   <= 1'b0;
              state    <= ACCESS;
            end else if (!hd_write || ACK_EN) begin
              rs_dst   <= hd_src;
              rs_write <= hd_write;
              rs_err   <= err;
              rs_rdata <= '0;
              rs_valid <= 1'b1;
              state    <= RESP;
            end
          end
        end
        ACCESS: begin
          rs_rdata <= sram_q;
          rs_valid <= 1'b1;
          state    <= RESP;
        end
        RESP: begin
          if (rs_ready) begin
            rs_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
